bp_cfg_profile_sequencer: RTL and testbench



---
 rtl/bp_cfg_profile_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_bp_cfg_profile_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_profile_sequencer.sv
// bp_cfg_profile_sequencer
//
// Stores num_profiles_p packed configuration profiles and switches the active
// profile across num_cores_p cores: freeze all cores, wait for every core to
// report idle, apply the selected profile, then release the cores.
//
// Ports:
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   w_v_i/w_idx_i/w_data_i    profile write request; w_ready_o handshake
//   sel_v_i/sel_idx_i         switch request; sel_ready_o high only in IDLE
//   freeze_o / idle_i         per-core freeze request and idle acknowledge
//   active_profile_o/_idx_o   currently applied profile and its slot index
//   busy_o                    high whenever a switch is in progress
//   done_v_o                  one-cycle pulse when a switch completes/aborts
//   err_o                     one-cycle pulse on abort or out-of-range select
//
// Build option:
//   BP_CFG_PROFILE_TIMEOUT_EN  when defined, DRAIN aborts after timeout_p
//                              cycles without all cores idle. When undefined,
//                              DRAIN waits indefinitely and timeout_p is unused.

module bp_cfg_profile_sequencer #(
  parameter int                          num_cores_p     = 4,
  parameter int                          num_profiles_p  = 4,
  parameter int                          profile_width_p = 64,
  parameter logic [profile_width_p-1:0]  reset_profile_p = '0,
  parameter int                          timeout_p       = 255,
  localparam int                         idx_width_lp    = $clog2(num_profiles_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       w_v_i,
  input  logic [idx_width_lp-1:0]    w_idx_i,
  input  logic [profile_width_p-1:0] w_data_i,
  output logic                       w_ready_o,
  input  logic                       sel_v_i,
  input  logic [idx_width_lp-1:0]    sel_idx_i,
  output logic                       sel_ready_o,
  output logic [num_cores_p-1:0]     freeze_o,
  input  logic [num_cores_p-1:0]     idle_i,
  output logic [profile_width_p-1:0] active_profile_o,
  output logic [idx_width_lp-1:0]    active_idx_o,
  output logic                       busy_o,
  output logic                       done_v_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_APPLY   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e                     r_state;
  logic [idx_width_lp-1:0]    r_pend_idx;
  logic [profile_width_p-1:0] r_mem [num_profiles_p];
  logic [profile_width_p-1:0] r_active_profile;
  logic [idx_width_lp-1:0]    r_active_idx;
  logic                       r_freeze;
  logic                       r_done;
  logic                       r_err;

  logic                       w_busy;
  logic                       w_sel_in_range;
  logic                       w_timeout;
  logic [num_profiles_p-1:0]  w_slot_we;

  assign w_busy = (r_state != ST_IDLE);

  // Only a write aimed at the slot being switched to is held off, so the
  // profile read in APPLY is exactly what was in the slot at select time.
  assign w_ready_o = !(w_busy && (w_idx_i == r_pend_idx));

  // Non-power-of-two slot counts leave unused index codes.
  assign w_sel_in_range = (32'(sel_idx_i) < 32'(num_profiles_p));

  // Out-of-range write indices match no slot and are silently dropped.
  for (genvar gi = 0; gi < num_profiles_p; gi++) begin : g_slot_we
    assign w_slot_we[gi] = w_v_i && w_ready_o && (w_idx_i == idx_width_lp'(gi));
  end

`ifdef BP_CFG_PROFILE_TIMEOUT_EN
  localparam int cnt_width_lp = (timeout_p < 1) ? 1 : $clog2(timeout_p + 1);

  logic [cnt_width_lp-1:0] r_to_cnt;
  logic                    w_to_sat;

  assign w_to_sat  = (32'(r_to_cnt) >= 32'(timeout_p));
  // Abort in the DRAIN cycle whose count would reach timeout_p, so the
  // fastest abort leaves DRAIN after exactly timeout_p cycles.
  assign w_timeout = ((32'(r_to_cnt) + 32'd1) >= 32'(timeout_p));

  // Held at zero outside a switch so it always starts DRAIN from zero.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_DRAIN) && !w_to_sat) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (timeout_p != 0);
  assign w_timeout        = 1'b0;
`endif

  // Profile storage; writes and select can hit the same slot in one cycle,
  // the write lands first and APPLY reads it two cycles later.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_profiles_p; i++) begin
        r_mem[i] <= (i == 0) ? reset_profile_p : '0;
      end
    end else begin
      for (int i = 0; i < num_profiles_p; i++) begin
        if (w_slot_we[i]) begin
          r_mem[i] <= w_data_i;
        end
      end
    end
  end

  // Switch sequencer with registered freeze/done/err outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state          <= ST_IDLE;
      r_pend_idx       <= '0;
      r_freeze         <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_active_profile <= reset_profile_p;
      r_active_idx     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sel_v_i) begin
            if (w_sel_in_range) begin
              r_pend_idx <= sel_idx_i;
              r_freeze   <= 1'b1;
              r_state    <= ST_DRAIN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (&idle_i) begin
            r_state <= ST_APPLY;
          end else if (w_timeout) begin
            // Abort: release the cores without touching the active profile.
            r_freeze <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= ST_RELEASE;
          end
        end
        ST_APPLY: begin
          r_active_profile <= r_mem[r_pend_idx];
          r_active_idx     <= r_pend_idx;
          r_freeze         <= 1'b0;
          r_done           <= 1'b1;
          r_state          <= ST_RELEASE;
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_ready_o      = !w_busy;
  assign busy_o           = w_busy;
  assign freeze_o         = {num_cores_p{r_freeze}};
  assign done_v_o         = r_done;
  assign err_o            = r_err;
  assign active_profile_o = r_active_profile;
  assign active_idx_o     = r_active_idx;

endmodule

// File: tb/tb_bp_cfg_profile_sequencer.sv
// Testbench for bp_cfg_profile_sequencer. Expected switch results are queued
// when a select is issued; a monitor pops them whenever done_v_o pulses.
// A second instance with three slots exercises the out-of-range select.

module tb_bp_cfg_profile_sequencer;

  localparam int NC = 4;
  localparam int NP = 4;
  localparam int PW = 64;
  localparam int IW = 2;

  typedef struct packed {
    logic [PW-1:0] prof;
    logic [IW-1:0] idx;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          w_v;
  logic [IW-1:0] w_idx;
  logic [PW-1:0] w_data;
  logic          w_ready;
  logic          sel_v;
  logic [IW-1:0] sel_idx;
  logic          sel_ready;
  logic [NC-1:0] freeze;
  logic [NC-1:0] idle;
  logic [PW-1:0] active_profile;
  logic [IW-1:0] active_idx;
  logic          busy;
  logic          done_v;
  logic          err;

  // Second instance (three slots)
  logic          b_w_ready;
  logic          b_sel_v;
  logic [IW-1:0] b_sel_idx;
  logic          b_sel_ready;
  logic [NC-1:0] b_freeze;
  logic [PW-1:0] b_active_profile;
  logic [IW-1:0] b_active_idx;
  logic          b_busy;
  logic          b_done_v;
  logic          b_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bp_cfg_profile_sequencer #(
    .num_cores_p(NC), .num_profiles_p(NP), .profile_width_p(PW),
    .reset_profile_p('0), .timeout_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .w_v_i(w_v), .w_idx_i(w_idx), .w_data_i(w_data), .w_ready_o(w_ready),
    .sel_v_i(sel_v), .sel_idx_i(sel_idx), .sel_ready_o(sel_ready),
    .freeze_o(freeze), .idle_i(idle),
    .active_profile_o(active_profile), .active_idx_o(active_idx),
    .busy_o(busy), .done_v_o(done_v), .err_o(err)
  );

  bp_cfg_profile_sequencer #(
    .num_cores_p(NC), .num_profiles_p(3), .profile_width_p(PW),
    .reset_profile_p('0), .timeout_p(8)
  ) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .w_v_i(1'b0), .w_idx_i(2'd0), .w_data_i(64'd0), .w_ready_o(b_w_ready),
    .sel_v_i(b_sel_v), .sel_idx_i(b_sel_idx), .sel_ready_o(b_sel_ready),
    .freeze_o(b_freeze), .idle_i(4'hF),
    .active_profile_o(b_active_profile), .active_idx_o(b_active_idx),
    .busy_o(b_busy), .done_v_o(b_done_v), .err_o(b_err)
  );

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [PW-1:0] prof, input logic [IW-1:0] idx, input logic e);
    exp_t x;
    x.prof = prof;
    x.idx  = idx;
    x.err  = e;
    exp_q.push_back(x);
    n_pushed++;
  endtask

  // Fastest switch with all cores idle; ends in the IDLE cycle after RELEASE.
  task automatic quick_switch(input logic [IW-1:0] idx, input logic [PW-1:0] prof);
    cyc();
    sel_v   = 1'b1;
    sel_idx = idx;
    push(prof, idx, 1'b0);
    cyc();
    sel_v = 1'b0;
    repeat (3) cyc();
  endtask

  // Monitor: one transaction line per completed or aborted switch.
  always @(negedge clk) begin
    if (reset_n && done_v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_unexpected actual=done required=no_done idx=%0d", active_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_popped++;
        $display("switch done: idx=%0d profile=%0h err=%0b (want idx=%0d profile=%0h err=%0b)",
                 active_idx, active_profile, err, e.idx, e.prof, e.err);
        chk("done_profile", active_profile, e.prof);
        chk("done_idx", 64'(active_idx), 64'(e.idx));
        chk("done_err", 64'(err), 64'(e.err));
        chk("done_freeze", 64'(freeze), 64'h0);
      end
    end
  end

  localparam logic [PW-1:0] SLOT1_V = 64'h1111_2222_3333_4444;
  localparam logic [PW-1:0] VAL_A   = 64'hAAAA_0000_0000_0003;
  localparam logic [PW-1:0] VAL_B   = 64'hBBBB_0000_0000_0003;
  localparam logic [PW-1:0] VAL_C   = 64'hCCCC_0000_0000_0001;

  initial begin
    reset_n   = 1'b0;
    w_v       = 1'b0;
    w_idx     = '0;
    w_data    = '0;
    sel_v     = 1'b0;
    sel_idx   = '0;
    idle      = 4'hF;
    b_sel_v   = 1'b0;
    b_sel_idx = '0;

    // Reset state
    repeat (3) cyc();
    smp();
    chk("rst_freeze", 64'(freeze), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done_v), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_active_idx", 64'(active_idx), 64'h0);
    chk("rst_active_profile", active_profile, 64'h0);
    chk("rst_sel_ready", 64'(sel_ready), 64'h1);
    chk("rst_w_ready", 64'(w_ready), 64'h1);
    cyc();
    reset_n = 1'b1;

    // Basic switch to slot 2
    w_v = 1'b1; w_idx = 2'd2; w_data = 64'hDEAD_BEEF;
    cyc();
    w_v = 1'b0; sel_v = 1'b1; sel_idx = 2'd2;
    push(64'hDEAD_BEEF, 2'd2, 1'b0);
    smp(); chk("c0_sel_ready", 64'(sel_ready), 64'h1);
    cyc(); sel_v = 1'b0;
    smp(); chk("c1_freeze", 64'(freeze), 64'hF);
    chk("c1_active_idx", 64'(active_idx), 64'h0);
    cyc(); smp(); chk("c2_freeze", 64'(freeze), 64'hF);
    chk("c2_active_profile", active_profile, 64'h0);
    cyc(); smp(); chk("c3_freeze", 64'(freeze), 64'h0);
    chk("c3_done", 64'(done_v), 64'h1);
    cyc(); smp(); chk("c4_sel_ready", 64'(sel_ready), 64'h1);
    chk("c4_busy", 64'(busy), 64'h0);
    chk("c4_done", 64'(done_v), 64'h0);

    // Drain wait on slot 1
    w_v = 1'b1; w_idx = 2'd1; w_data = SLOT1_V;
    cyc();
    w_v = 1'b0; sel_v = 1'b1; sel_idx = 2'd1; idle = 4'b0111;
    push(SLOT1_V, 2'd1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); sel_v = 1'b0;
      smp();
      chk("drain_freeze", 64'(freeze), 64'hF);
      chk("drain_busy", 64'(busy), 64'h1);
    end
    cyc(); idle = 4'hF;                      // cycle 6
    smp(); chk("drain6_freeze", 64'(freeze), 64'hF);
    cyc(); smp();                            // cycle 7: APPLY
    chk("apply_freeze", 64'(freeze), 64'hF);
    chk("apply_active_idx_old", 64'(active_idx), 64'h2);
    cyc(); smp();                            // cycle 8: RELEASE
    chk("release_active_idx", 64'(active_idx), 64'h1);
    cyc();

`ifdef BP_CFG_PROFILE_TIMEOUT_EN
    // Timeout abort
    sel_v = 1'b1; sel_idx = 2'd3; idle = 4'b1110;
    push(SLOT1_V, 2'd1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cyc(); sel_v = 1'b0;
      smp(); chk("to_drain_freeze", 64'(freeze), 64'hF);
    end
    cyc(); smp();                            // cycle 9
    chk("to_release_done", 64'(done_v), 64'h1);
    chk("to_release_err", 64'(err), 64'h1);
    chk("to_active_profile", active_profile, SLOT1_V);
    cyc(); idle = 4'hF;
    smp(); chk("to_idle_busy", 64'(busy), 64'h0);
    cyc();
`endif

    // Write stall during switch to slot 3
    w_v = 1'b1; w_idx = 2'd3; w_data = VAL_A;
    cyc();
    w_v = 1'b0; sel_v = 1'b1; sel_idx = 2'd3; idle = 4'b0111;
    push(VAL_A, 2'd3, 1'b0);
    cyc(); sel_v = 1'b0; w_v = 1'b1; w_idx = 2'd3; w_data = VAL_B;   // cycle 1
    smp(); chk("stall_c1", 64'(w_ready), 64'h0);
    cyc(); smp(); chk("stall_c2", 64'(w_ready), 64'h0);
    cyc(); w_idx = 2'd1; w_data = VAL_C;                             // cycle 3
    smp(); chk("other_slot_ready", 64'(w_ready), 64'h1);
    cyc(); w_idx = 2'd3; w_data = VAL_B; idle = 4'hF;                // cycle 4
    smp(); chk("stall_c4", 64'(w_ready), 64'h0);
    cyc(); smp(); chk("stall_apply", 64'(w_ready), 64'h0);
    cyc(); smp(); chk("stall_release", 64'(w_ready), 64'h0);
    cyc(); smp(); chk("stall_idle_ready", 64'(w_ready), 64'h1);
    cyc(); w_v = 1'b0;
    quick_switch(2'd1, VAL_C);
    quick_switch(2'd3, VAL_B);

    // Same-cycle write and select of slot 0, then re-apply
    cyc();
    w_v = 1'b1; w_idx = 2'd0; w_data = 64'h55;
    sel_v = 1'b1; sel_idx = 2'd0;
    push(64'h55, 2'd0, 1'b0);
    cyc(); w_v = 1'b0; sel_v = 1'b0;
    smp(); chk("same_cycle_freeze", 64'(freeze), 64'hF);
    repeat (3) cyc();
    quick_switch(2'd0, 64'h55);

    // Mid-switch reset
    cyc();
    sel_v = 1'b1; sel_idx = 2'd2; idle = 4'b0111;
    cyc(); sel_v = 1'b0;                     // cycle 1: DRAIN
    cyc(); reset_n = 1'b0;                   // cycle 2
    cyc(); smp();                            // after reset edge
    chk("midrst_freeze", 64'(freeze), 64'h0);
    chk("midrst_profile", active_profile, 64'h0);
    chk("midrst_idx", 64'(active_idx), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    cyc(); reset_n = 1'b1; idle = 4'hF;
    quick_switch(2'd2, 64'h0);
    quick_switch(2'd1, 64'h0);

    // Out-of-range select on the three-slot instance
    cyc();
    b_sel_v = 1'b1; b_sel_idx = 2'd3;
    smp(); chk("b_sel_ready", 64'(b_sel_ready), 64'h1);
    cyc(); b_sel_v = 1'b0;
    smp();
    $display("oor select: err=%0b freeze=%0h busy=%0b done=%0b", b_err, b_freeze, b_busy, b_done_v);
    chk("b_oor_err", 64'(b_err), 64'h1);
    chk("b_oor_freeze", 64'(b_freeze), 64'h0);
    chk("b_oor_busy", 64'(b_busy), 64'h0);
    chk("b_oor_done", 64'(b_done_v), 64'h0);
    cyc(); smp();
    chk("b_oor_err_pulse", 64'(b_err), 64'h0);
    chk("b_oor_freeze_after", 64'(b_freeze), 64'h0);

    repeat (3) cyc();
    smp();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    chk("done_count", 64'(n_popped), 64'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
